// File: rtl/face_fetch.sv
// Purpose : streams faces 0..FACES-1 from a 1-cycle synchronous object memory
//           into a 3-entry FIFO, presented downstream on valid/ready with
//           index and last tags.
// Latency : start in cycle 0 -> read of addr 0 in cycle 1 -> face 0 valid in cycle 3.
// Backpressure: reads are issued only while FIFO occupancy plus the in-flight
//           read is below 3, so the FIFO never overflows.
// Ports   : i_clk/i_rst_n (async active-low), i_start -> o_busy/o_done;
//           o_mem_rd_en/o_mem_addr/i_mem_data memory read port;
//           o_face_out/o_face_idx/o_face_last/o_face_valid/i_face_ready downstream.
module face_fetch #(
  parameter int FACES  = 92,
  parameter int ADDR_W = 7,
  parameter int FACE_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_mem_rd_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [FACE_W-1:0] i_mem_data,
  output logic [FACE_W-1:0] o_face_out,
  output logic [ADDR_W-1:0] o_face_idx,
  output logic              o_face_last,
  output logic              o_face_valid,
  input  logic              i_face_ready
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FACES - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  typedef struct packed {
    logic [FACE_W-1:0] face;
    logic [ADDR_W-1:0] idx;
    logic              last;
  } entry_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cntr;      // next address to issue
  logic [ADDR_W-1:0] r_addr;      // last issued address; tags the returning face
  logic              r_inflight;  // a read was issued last cycle
  logic [1:0]        r_occ;
  logic [1:0]        r_wr_ptr;
  logic [1:0]        r_rd_ptr;
  entry_t            r_fifo [3];

  logic              w_credit_ok;
  logic              w_drained;
  logic              w_start_ok;
  logic              w_push;
  logic              w_pop;
  entry_t            w_entry;
  entry_t            w_head;

  // Credit check uses only registered state, so face_ready never reaches
  // the memory read strobe combinationally.
  assign w_credit_ok = (({1'b0, r_occ} + {2'b00, r_inflight}) < 3'd3);
  assign w_drained   = (r_occ == 2'd0) && !r_inflight;
  // A start in the done cycle launches the next sweep immediately.
  assign w_start_ok  = i_start && ((r_state == S_IDLE) || o_done);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_FETCH;
      S_FETCH: if (o_mem_rd_en && (r_cntr == LAST_IDX)) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_drained) w_state_nxt = i_start ? S_FETCH : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_mem_rd_en = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_busy      = 1'b1;
        o_mem_rd_en = w_credit_ok;
      end
      S_DRAIN: begin
        o_busy = !w_drained;
        o_done = w_drained;
      end
      default: ;
    endcase
  end

  // Address holds the last issued value while no read is being issued.
  assign o_mem_addr = o_mem_rd_en ? r_cntr : r_addr;

  // ---------------- read counter / in-flight tracking ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cntr     <= '0;
      r_addr     <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= o_mem_rd_en;
      if (w_start_ok) begin
        r_cntr <= '0;
        r_addr <= '0;
      end else if (o_mem_rd_en) begin
        r_cntr <= r_cntr + ADDR_W'(1);
        r_addr <= r_cntr;
      end
    end
  end

  // ---------------- 3-entry FIFO ----------------
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign w_push       = r_inflight;
  assign w_pop        = o_face_valid && i_face_ready;
  assign w_entry.face = i_mem_data;
  assign w_entry.idx  = r_addr;
  assign w_entry.last = (r_addr == LAST_IDX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_occ    <= 2'd0;
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Storage needs no reset: entries are only observable while occupied.
  always_ff @(posedge i_clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_entry;
  end

  assign w_head       = r_fifo[r_rd_ptr];
  assign o_face_valid = (r_occ != 2'd0);
  assign o_face_out   = o_face_valid ? w_head.face : '0;
  assign o_face_idx   = o_face_valid ? w_head.idx  : '0;
  assign o_face_last  = o_face_valid ? w_head.last : 1'b0;

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(w_push && !w_pop && (r_occ == 2'd3)));

endmodule

// File: tb/tb_face_fetch.sv
module tb_face_fetch;
  localparam int FACES = 92;
  localparam int AW    = 7;
  localparam int FW    = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start;
  logic          face_ready;
  logic          busy, done, rd_en, face_last, face_valid;
  logic [AW-1:0] mem_addr, face_idx;
  logic [FW-1:0] mem_data = '0;
  logic [FW-1:0] face_out;

  logic          s1_start;
  logic          s1_ready;
  logic          s1_busy, s1_done, s1_rd_en, s1_last, s1_valid;
  logic [0:0]    s1_addr, s1_idx;
  logic [FW-1:0] s1_data = '0;
  logic [FW-1:0] s1_out;

  face_fetch #(.FACES(FACES), .ADDR_W(AW), .FACE_W(FW)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_busy(busy), .o_done(done),
    .o_mem_rd_en(rd_en), .o_mem_addr(mem_addr), .i_mem_data(mem_data),
    .o_face_out(face_out), .o_face_idx(face_idx), .o_face_last(face_last),
    .o_face_valid(face_valid), .i_face_ready(face_ready));

  face_fetch #(.FACES(1), .ADDR_W(1), .FACE_W(FW)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(s1_start), .o_busy(s1_busy), .o_done(s1_done),
    .o_mem_rd_en(s1_rd_en), .o_mem_addr(s1_addr), .i_mem_data(s1_data),
    .o_face_out(s1_out), .o_face_idx(s1_idx), .o_face_last(s1_last),
    .o_face_valid(s1_valid), .i_face_ready(s1_ready));

  // Object memory contents: a fixed scramble of the address.
  function automatic logic [31:0] fdata(input int a);
    return 32'hC0DE0000 ^ (32'(a) * 32'h01000193) ^ 32'h00005A5A;
  endfunction

  // Synchronous read ports: data appears the cycle after the strobe.
  always @(posedge clk) if (rd_en)    mem_data <= fdata(int'(mem_addr));
  always @(posedge clk) if (s1_rd_en) s1_data  <= fdata(int'(s1_addr));

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: reads issued, faces taken, last tags and done pulses seen.
  int m_reads, m_taken, m_last_cnt, m_done_cnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_reads = 0; m_taken = 0; m_last_cnt = 0; m_done_cnt = 0;
  endtask

  task automatic step();
    @(posedge clk); #1; cyc++;
  endtask

  // Apply inputs for this cycle, then observe: reads must walk 0,1,2,... and
  // never exceed 3 outstanding faces; handshakes must deliver faces in order.
  task automatic drive(input bit st, input bit rdy);
    start = st; face_ready = rdy; #1;
    if (rst_n) begin
      if (rd_en) begin
        chk("rd_addr", 64'(mem_addr), 64'(m_reads));
        chk("credit", 64'((m_reads - m_taken) < 3), 64'd1);
        m_reads++;
      end
      if (face_valid && face_ready) begin
        chk("hs_idx",  64'(face_idx),  64'(m_taken));
        chk("hs_data", 64'(face_out),  64'(fdata(m_taken)));
        chk("hs_last", 64'(face_last), 64'(m_taken == FACES - 1));
        if (face_last) m_last_cnt++;
        m_taken++;
      end
      if (done) m_done_cnt++;
    end
  endtask

  task automatic run_until_done(input bit rnd, input int budget);
    int k = 0;
    while (m_done_cnt == 0 && k < budget) begin
      drive(1'b0, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      if (m_done_cnt == 0) step();
      k++;
    end
    chk("done_within_budget", 64'(m_done_cnt), 64'd1);
    step();
  endtask

  typedef struct packed {
    logic st, rdy, busy, done, rd;
    logic [AW-1:0] addr;
    logic vld;
    logic [AW-1:0] idx;
  } vec_t;

  function automatic vec_t mk(input int st, rdy, bz, dn, rd, ad, vl, ix);
    vec_t v;
    v.st = 1'(st); v.rdy = 1'(rdy); v.busy = 1'(bz); v.done = 1'(dn); v.rd = 1'(rd);
    v.addr = AW'(ad); v.vld = 1'(vl); v.idx = AW'(ix);
    return v;
  endfunction

  vec_t tbl [12];

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; s1_start = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    // Stall sequence: ready low after start, then raised in cycle 7.
    //            st rdy busy done rd addr vld idx
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 1, 0, 1, 0, 0, 0);
    tbl[2]  = mk(0, 0, 1, 0, 1, 1, 0, 0);
    tbl[3]  = mk(0, 0, 1, 0, 1, 2, 1, 0);
    tbl[4]  = mk(0, 0, 1, 0, 0, 2, 1, 0);
    tbl[5]  = mk(0, 0, 1, 0, 0, 2, 1, 0);
    tbl[6]  = mk(0, 0, 1, 0, 0, 2, 1, 0);
    tbl[7]  = mk(0, 1, 1, 0, 0, 2, 1, 0);
    tbl[8]  = mk(0, 1, 1, 0, 1, 3, 1, 1);
    tbl[9]  = mk(0, 1, 1, 0, 1, 4, 1, 2);
    tbl[10] = mk(0, 1, 1, 0, 1, 5, 1, 3);
    tbl[11] = mk(0, 1, 1, 0, 1, 6, 1, 4);

    rst_n = 1'b0; start = 1'b0; face_ready = 1'b1; s1_start = 1'b0; s1_ready = 1'b1;
    model_reset();
    #3;
    chk("rst_busy",  64'(busy), 0);       chk("rst_done",  64'(done), 0);
    chk("rst_rd_en", 64'(rd_en), 0);      chk("rst_addr",  64'(mem_addr), 0);
    chk("rst_valid", 64'(face_valid), 0); chk("rst_idx",   64'(face_idx), 0);
    chk("rst_last",  64'(face_last), 0);  chk("rst_out",   64'(face_out), 0);
    chk("rst1_valid", 64'(s1_valid), 0);  chk("rst1_busy", 64'(s1_busy), 0);
    do_reset();

    // 1: full sweep with ready held high; timing from plain arithmetic.
    model_reset(); cyc = 0;
    for (int c = 0; c <= FACES + 4; c++) begin
      drive(c == 0, 1'b1);
      chk("t1_busy",  64'(busy),  64'(c >= 1 && c <= FACES + 2));
      chk("t1_done",  64'(done),  64'(c == FACES + 3));
      chk("t1_rd_en", 64'(rd_en), 64'(c >= 1 && c <= FACES));
      chk("t1_addr",  64'(mem_addr), 64'(c == 0 ? 0 : (c <= FACES ? c - 1 : FACES - 1)));
      chk("t1_valid", 64'(face_valid), 64'(c >= 3 && c <= FACES + 2));
      if (c >= 3 && c <= FACES + 2) begin
        chk("t1_idx",  64'(face_idx),  64'(c - 3));
        chk("t1_last", 64'(face_last), 64'(c - 3 == FACES - 1));
      end
      step();
    end
    chk("t1_count", 64'(m_taken), 64'(FACES));
    chk("t1_lasts", 64'(m_last_cnt), 1);
    chk("t1_dones", 64'(m_done_cnt), 1);

    // 2: back-pressure table, then finish the sweep.
    do_reset();
    model_reset(); cyc = 0;
    foreach (tbl[i]) begin
      drive(tbl[i].st, tbl[i].rdy);
      chk("t2_busy",  64'(busy),  64'(tbl[i].busy));
      chk("t2_done",  64'(done),  64'(tbl[i].done));
      chk("t2_rd_en", 64'(rd_en), 64'(tbl[i].rd));
      chk("t2_addr",  64'(mem_addr), 64'(tbl[i].addr));
      chk("t2_valid", 64'(face_valid), 64'(tbl[i].vld));
      if (tbl[i].vld) begin
        chk("t2_idx",  64'(face_idx), 64'(tbl[i].idx));
        chk("t2_data", 64'(face_out), 64'(fdata(int'(tbl[i].idx))));
      end
      step();
    end
    run_until_done(1'b0, 500);
    chk("t2_count", 64'(m_taken), 64'(FACES));

    // 3: random back-pressure over a full sweep.
    model_reset(); cyc = 0;
    drive(1'b1, 1'($urandom_range(0, 1)));
    step();
    run_until_done(1'b1, 3000);
    chk("t3_count", 64'(m_taken), 64'(FACES));
    chk("t3_lasts", 64'(m_last_cnt), 1);
    chk("t3_busy_after", 64'(busy), 0);

    // 4: starts while busy are ignored; start in the done cycle relaunches.
    model_reset(); cyc = 0;
    for (int c = 0; c <= FACES + 3; c++) begin
      drive(c == 0 || c == 10 || c == 50 || c == FACES + 3, 1'b1);
      if (c == FACES + 3) begin
        chk("t4_done",  64'(done), 1);
        chk("t4_count", 64'(m_taken), 64'(FACES));
        chk("t4_dones", 64'(m_done_cnt), 1);
        model_reset();
      end
      step();
    end
    drive(1'b0, 1'b1);
    chk("t4_restart_rd",   64'(rd_en), 1);
    chk("t4_restart_addr", 64'(mem_addr), 0);
    chk("t4_restart_busy", 64'(busy), 1);
    step();
    run_until_done(1'b0, 500);
    chk("t4_count2", 64'(m_taken), 64'(FACES));

    // 5: reset mid-stream, then a clean restart.
    model_reset(); cyc = 0;
    for (int c = 0; c < 40; c++) begin
      drive(c == 0, 1'b1);
      step();
    end
    drive(1'b0, 1'b1);
    rst_n = 1'b0; #1;
    chk("t5_busy",  64'(busy), 0);       chk("t5_valid", 64'(face_valid), 0);
    chk("t5_rd_en", 64'(rd_en), 0);      chk("t5_done",  64'(done), 0);
    chk("t5_addr",  64'(mem_addr), 0);   chk("t5_idx",   64'(face_idx), 0);
    chk("t5_out",   64'(face_out), 0);
    step(); step();
    rst_n = 1'b1;
    step();
    drive(1'b0, 1'b1);
    chk("t5_idle_valid", 64'(face_valid), 0);
    step();
    model_reset(); cyc = 0;
    drive(1'b1, 1'b1);
    step();
    run_until_done(1'b0, 500);
    chk("t5_count", 64'(m_taken), 64'(FACES));
    chk("t5_lasts", 64'(m_last_cnt), 1);

    // 6: single-face build.
    cyc = 0;
    s1_start = 1'b1; #1;
    chk("t6_busy0", 64'(s1_busy), 0);
    step(); s1_start = 1'b0; #1;
    chk("t6_rd1",   64'(s1_rd_en), 1);  chk("t6_addr1", 64'(s1_addr), 0);
    chk("t6_busy1", 64'(s1_busy), 1);
    step(); #1;
    chk("t6_rd2",   64'(s1_rd_en), 0);  chk("t6_valid2", 64'(s1_valid), 0);
    step(); #1;
    chk("t6_valid3", 64'(s1_valid), 1); chk("t6_idx3",  64'(s1_idx), 0);
    chk("t6_last3",  64'(s1_last), 1);  chk("t6_data3", 64'(s1_out), 64'(fdata(0)));
    chk("t6_done3",  64'(s1_done), 0);
    step(); #1;
    chk("t6_done4",  64'(s1_done), 1);  chk("t6_busy4", 64'(s1_busy), 0);
    chk("t6_valid4", 64'(s1_valid), 0);
    step(); #1;
    chk("t6_done5",  64'(s1_done), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/face_fetch.md
Name: face_fetch

Overview:
Streaming front end between the object memory and the GPU face pipeline. On a start pulse it sweeps face addresses 0..FACES-1 through the object memory's 1-cycle synchronous read port. It buffers returned faces in a 3-entry FIFO and presents them downstream on a valid/ready handshake with index and last tags. Memory latency and downstream back-pressure are therefore hidden from the GPU core.

Parameters:
FACES, 92, number of faces in object memory (>= 1)
ADDR_W, 7, width of face address/index; must satisfy 2**ADDR_W >= FACES

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle request to stream all faces; ignored while busy=1
busy  out  1  high from the cycle after an accepted start until the done cycle
done  out  1  one-cycle pulse after the final face handshake
mem_rd_en  out  1  read strobe to object memory
mem_addr  out  ADDR_W  face address to object memory (face_cntr)
mem_data  in  Face_t  read data, valid the cycle after mem_rd_en
face_out  out  Face_t  face at FIFO head
face_idx  out  ADDR_W  index of face_out
face_last  out  1  face_idx == FACES-1
face_valid  out  1  FIFO non-empty
face_ready  in  1  downstream accepts when face_valid && face_ready

Behaviour:
- Reset (reset=0, async): state IDLE, FIFO empty, read counter=0, inflight=0; outputs busy=0, done=0, mem_rd_en=0, mem_addr=0, face_valid=0, face_idx=0, face_last=0, face_out=0. Reset mid-stream discards all buffered and in-flight data; a read returned after reset is not captured.
- States: IDLE, FETCH, DRAIN.
- IDLE: start=1 -> FETCH, read counter=0. busy=1 next cycle.
- FETCH: mem_rd_en=1, mem_addr=read counter iff occ+inflight < 3. occ is the registered FIFO occupancy; inflight is the registered mem_rd_en of the previous cycle. On issue, counter increments. The issue of address FACES-1 moves to DRAIN. No combinational path from face_ready to mem_rd_en/mem_addr.
- Capture: when inflight=1, mem_data is pushed with index=issued address and last=(index==FACES-1).
- DRAIN: mem_rd_en=0. When occ=0 and inflight=0: done=1 for that cycle, busy=0, state IDLE. start is accepted in that same cycle.
- Output: face_valid=(occ!=0). face_out, face_idx and face_last stay stable while face_valid && !face_ready. Pop on handshake; a simultaneous push and pop leaves occ unchanged. FIFO never overflows (credit rule); overflow is an assertion-level error.
- Latency: start in cycle 0 -> read addr 0 in cycle 1 -> face 0 valid in cycle 3.
- Throughput: 1 face/cycle with face_ready held high.
- With face_ready=1 throughout: faces in cycles 3..FACES+2, done in cycle FACES+3.
- mem_addr holds its last value when mem_rd_en=0; it returns to 0 only on reset or accepted start.
- FACES=1: one read, face_last=1 on the only face.

Test Plan:
1. Reset, start pulse cycle 0, face_ready=1, FACES=92 -> mem_addr 0..91 in cycles 1..92; face_valid cycles 3..94 with face_idx 0..91; face_last only at idx 91; done pulse cycle 95; busy 1 in cycles 1..94.
2. face_ready=0 after start -> reads of addr 0,1,2 only (cycles 1-3); mem_rd_en=0 from cycle 4; face_valid=1 holding idx 0 stable. Raise ready -> idx 0,1,2 emerge back-to-back and reads resume at addr 3.
3. Random face_ready (50%) over the full sweep -> all 92 faces delivered in order, data equal to memory model, exactly one face_last and one done; no FIFO overflow assertion.
4. start pulses while busy (cycles 10, 50) -> ignored; single sweep of 92 faces. start in the done cycle -> second sweep begins, addr 0 read the next cycle.
5. reset asserted mid-stream (cycle 40, face_ready=1) -> same cycle busy=0, face_valid=0, mem_rd_en=0. After release and a new start -> sweep restarts at idx 0 with no stale faces.
6. FACES=1 build: start -> one read of addr 0, face_valid cycle 3 with face_idx=0, face_last=1; done cycle 4.
